// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: sequential instruction fetch with bounded outstanding reads feeding a DEPTH-entry decode queue
// Optional build macro FETCH_QUEUE_BYPASS_EN: an empty queue presents a bus response to decode in the same cycle.
module rv_fetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RVEC = '0,
  parameter int MAX_OS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         mem_req,
  output logic [XLEN-1:0]              mem_addr,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [XLEN-1:0]              mem_rdata,
  input  logic                         mem_err,
  output logic                         inst_valid,
  input  logic                         inst_ready,
  output logic [XLEN-1:0]              inst,
  output logic [XLEN-1:0]              inst_pc,
  output logic                         inst_err,
  output logic [$clog2(MAX_OS+1)-1:0]  os_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OS + 1);
  localparam int PW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] dat_q [DEPTH];
  logic [XLEN-1:0] ipc_q [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [XLEN-1:0] opc_q [MAX_OS];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] os_q, os_d, drop_q, drop_d;
  logic [PW-1:0] ow_q, ow_d, or_q, or_d;
  logic [XLEN-1:0] resp_pc;
  logic issue, keep, byp, head, pop, take, push;
  // Issue credit, response steering, head presentation and next-state arithmetic
  always_comb begin
    mem_req = !rst && !redirect && (32'(os_q) < 32'(MAX_OS)) && (32'(cnt_q) + 32'(os_q) < 32'(DEPTH));
    mem_addr = pc_q;
    issue = mem_req && mem_gnt;
    keep = mem_rvalid && (drop_q == '0) && !redirect;
    resp_pc = opc_q[or_q];
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = keep && (cnt_q == '0);
`else
    byp = 1'b0;
`endif
    head = cnt_q != '0;
    inst_valid = head || byp;
    inst = head ? dat_q[rp_q] : (byp ? mem_rdata : '0);
    inst_pc = head ? ipc_q[rp_q] : (byp ? resp_pc : '0);
    inst_err = head ? err_q[rp_q] : (byp && mem_err);
    os_count = os_q;
    pop = head && inst_ready && !redirect;
    take = byp && inst_ready;
    push = keep && !take;
    pc_d = redirect ? {redirect_pc[XLEN-1:2], 2'b00} : (issue ? pc_q + XLEN'(4) : pc_q);
    os_d = os_q + OW'(issue) - OW'(mem_rvalid);
    drop_d = redirect ? os_q - OW'(mem_rvalid) : ((mem_rvalid && drop_q != '0) ? drop_q - OW'(1) : drop_q);
    cnt_d = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
    wp_d = redirect ? '0 : wp_q + AW'(push);
    rp_d = redirect ? '0 : rp_q + AW'(pop);
    ow_d = issue ? ((ow_q == PW'(MAX_OS - 1)) ? '0 : ow_q + PW'(1)) : ow_q;
    or_d = mem_rvalid ? ((or_q == PW'(MAX_OS - 1)) ? '0 : or_q + PW'(1)) : or_q;
  end
  // Control state: fetch PC, queue pointers, outstanding and drop counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RVEC;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      os_q <= '0;
      drop_q <= '0;
      ow_q <= '0;
      or_q <= '0;
    end else begin
      pc_q <= pc_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      os_q <= os_d;
      drop_q <= drop_d;
      ow_q <= ow_d;
      or_q <= or_d;
    end
  end
  // Storage: queue entries on push, issue-order PCs on issue; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push) begin
      dat_q[wp_q] <= mem_rdata;
      ipc_q[wp_q] <= resp_pc;
      err_q[wp_q] <= mem_err;
    end
    if (issue) opc_q[ow_q] <= pc_q;
  end
endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb_rv_fetch_queue: directed vector table, hand-written corner sequences and a random run against a queue-level model
module tb_rv_fetch_queue;
  localparam int DEPTH = 4;
  localparam int MAX_OS = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, redirect, mem_req, mem_gnt, mem_rvalid, mem_err, inst_valid, inst_ready, inst_err;
  logic [31:0] redirect_pc, mem_addr, mem_rdata, inst, inst_pc;
  logic [1:0] os_count;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  rv_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RVEC(32'h0), .MAX_OS(MAX_OS)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_err(mem_err), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err), .os_count(os_count)
  );
  typedef struct {
    logic rd; logic [31:0] rpc; logic gnt; logic rv; logic [31:0] rdata; logic err; logic rdy;
    logic req; logic [31:0] addr; logic vld; logic [31:0] ipc; logic ierr; logic [1:0] os;
  } vec_t;
  vec_t tv [21];
  typedef struct { logic [31:0] pc; logic [31:0] d; logic e; } ent_t;
  ent_t fq [$];
  logic [31:0] osq [$];
  logic [31:0] m_pc;
  int m_drop;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask
  task automatic cyc(input logic rd, input logic [31:0] rpc, input logic gnt, input logic rv,
                     input logic [31:0] rdata, input logic err, input logic rdy);
    @(negedge clk);
    redirect = rd; redirect_pc = rpc; mem_gnt = gnt; mem_rvalid = rv;
    mem_rdata = rdata; mem_err = err; inst_ready = rdy;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; mem_err = 1'b0; inst_ready = 1'b0;
    #1 chk("rst_req", 32'(mem_req), 0);
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_err", 32'(inst_err), 0);
    chk("rst_os", 32'(os_count), 0);
    rst = 1'b0;
    fq.delete(); osq.delete(); m_pc = 32'h0; m_drop = 0;
  endtask
  task automatic model_step();
    bit e_req, byp_v, e_vld, was_empty;
    e_req = !redirect && osq.size() < MAX_OS && fq.size() + osq.size() < DEPTH;
    byp_v = BYP && fq.size() == 0 && m_drop == 0 && mem_rvalid && !redirect;
    e_vld = fq.size() > 0 || byp_v;
    chk("m_req", 32'(mem_req), 32'(e_req));
    if (e_req) chk("m_addr", mem_addr, m_pc);
    chk("m_valid", 32'(inst_valid), 32'(e_vld));
    if (fq.size() > 0) begin
      chk("m_inst", inst, fq[0].d);
      chk("m_ipc", inst_pc, fq[0].pc);
      chk("m_ierr", 32'(inst_err), 32'(fq[0].e));
    end else if (byp_v) begin
      chk("m_byp_inst", inst, mem_rdata);
      chk("m_byp_pc", inst_pc, osq[0]);
    end
    chk("m_os", 32'(os_count), osq.size());
    was_empty = fq.size() == 0;
    if (!redirect && inst_ready && !was_empty) void'(fq.pop_front());
    if (mem_rvalid) begin
      ent_t e;
      e.pc = osq.pop_front(); e.d = mem_rdata; e.e = mem_err;
      if (m_drop > 0) m_drop--;
      else if (!redirect && !(byp_v && inst_ready)) fq.push_back(e);
    end
    if (e_req && mem_gnt) begin
      osq.push_back(m_pc);
      m_pc += 32'd4;
    end
    if (redirect) begin
      fq.delete();
      m_drop = osq.size();
      m_pc = redirect_pc & ~32'h3;
    end
  endtask
  initial begin
    tv[0]  = '{0, 0, 1, 0, 0, 0, 1,             1, 32'h0,   0, 0, 0, 0};
    tv[1]  = '{0, 0, 1, 1, 32'hD0000000, 0, 1,  1, 32'h4,   0, 0, 0, 1};
    tv[2]  = '{0, 0, 1, 1, 32'hD0000004, 0, 1,  1, 32'h8,   1, 32'h0, 0, 1};
    tv[3]  = '{0, 0, 1, 1, 32'hD0000008, 1, 1,  1, 32'hC,   1, 32'h4, 0, 1};
    tv[4]  = '{0, 0, 1, 1, 32'hD000000C, 0, 1,  1, 32'h10,  1, 32'h8, 1, 1};
    tv[5]  = '{0, 0, 1, 1, 32'hD0000010, 0, 0,  1, 32'h14,  1, 32'hC, 0, 1};
    tv[6]  = '{0, 0, 1, 0, 0, 0, 0,             1, 32'h18,  1, 32'hC, 0, 1};
    tv[7]  = '{0, 0, 1, 1, 32'hD0000014, 0, 0,  0, 0,       1, 32'hC, 0, 2};
    tv[8]  = '{0, 0, 1, 1, 32'hD0000018, 0, 0,  0, 0,       1, 32'hC, 0, 1};
    tv[9]  = '{0, 0, 1, 0, 0, 0, 0,             0, 0,       1, 32'hC, 0, 0};
    tv[10] = '{0, 0, 0, 0, 0, 0, 1,             0, 0,       1, 32'hC, 0, 0};
    tv[11] = '{0, 0, 1, 0, 0, 0, 0,             1, 32'h1C,  1, 32'h10, 0, 0};
    tv[12] = '{0, 0, 1, 0, 0, 0, 0,             0, 0,       1, 32'h10, 0, 1};
    tv[13] = '{0, 0, 0, 0, 0, 0, 1,             0, 0,       1, 32'h10, 0, 1};
    tv[14] = '{0, 0, 1, 0, 0, 0, 0,             1, 32'h20,  1, 32'h14, 0, 1};
    tv[15] = '{1, 32'h103, 1, 0, 0, 0, 1,       0, 0,       1, 32'h14, 0, 2};
    tv[16] = '{0, 0, 0, 1, 32'hD000001C, 0, 1,  0, 0,       0, 0, 0, 2};
    tv[17] = '{0, 0, 1, 1, 32'hD0000020, 0, 1,  1, 32'h100, 0, 0, 0, 1};
    tv[18] = '{0, 0, 0, 1, 32'hD0000100, 0, 1,  1, 32'h104, 0, 0, 0, 1};
    tv[19] = '{0, 0, 0, 0, 0, 0, 1,             1, 32'h104, 1, 32'h100, 0, 0};
    tv[20] = '{0, 0, 0, 0, 0, 0, 1,             1, 32'h104, 0, 0, 0, 0};
    do_reset();
`ifndef FETCH_QUEUE_BYPASS_EN
    for (int i = 0; i < 21; i++) begin
      cyc(tv[i].rd, tv[i].rpc, tv[i].gnt, tv[i].rv, tv[i].rdata, tv[i].err, tv[i].rdy);
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(tv[i].req));
      if (tv[i].req) chk($sformatf("v%0d_addr", i), mem_addr, tv[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tv[i].vld));
      if (tv[i].vld) begin
        chk($sformatf("v%0d_ipc", i), inst_pc, tv[i].ipc);
        chk($sformatf("v%0d_inst", i), inst, 32'hD0000000 | tv[i].ipc);
        chk($sformatf("v%0d_ierr", i), 32'(inst_err), 32'(tv[i].ierr));
      end
      chk($sformatf("v%0d_os", i), 32'(os_count), 32'(tv[i].os));
    end
`endif
    cyc(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("wrap_req", 32'(mem_req), 1);
    chk("wrap_addr0", mem_addr, 32'hFFFFFFFC);
    cyc(0, 0, 0, 1, 32'h12345678, 0, 0);
    chk("wrap_addr1", mem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("wrap_valid", 32'(inst_valid), 1);
    chk("wrap_ipc", inst_pc, 32'hFFFFFFFC);
    chk("wrap_inst", inst, 32'h12345678);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_drained", 32'(inst_valid), 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'hAAAA0000, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("rr_req", 32'(mem_req), 1);
    chk("rr_addr", mem_addr, 32'h8);
    cyc(1, 32'h200, 1, 1, 32'hAAAA0004, 0, 1);
    chk("rr_os2", 32'(os_count), 2);
    chk("rr_req_off", 32'(mem_req), 0);
    cyc(0, 0, 0, 1, 32'hAAAA0008, 0, 0);
    chk("rr_empty", 32'(inst_valid), 0);
    chk("rr_os1", 32'(os_count), 1);
    chk("rr_addr", mem_addr, 32'h200);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("rr_os0", 32'(os_count), 0);
    chk("rr_still_empty", 32'(inst_valid), 0);
    cyc(0, 0, 0, 1, 32'hBBBB0200, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("rr_new_valid", 32'(inst_valid), 1);
    chk("rr_new_pc", inst_pc, 32'h200);
    chk("rr_new_inst", inst, 32'hBBBB0200);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("byp_idle", 32'(inst_valid), 0);
    cyc(0, 0, 0, 1, 32'hCCCC0204, 0, 1);
    chk("byp_same", 32'(inst_valid), 32'(BYP));
    if (BYP) chk("byp_pc", inst_pc, 32'h204);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("byp_next", 32'(inst_valid), 32'(!BYP));
    if (!BYP) chk("byp_next_pc", inst_pc, 32'h204);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("byp_done", 32'(inst_valid), 0);
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      redirect = ($urandom % 16) == 0;
      redirect_pc = $urandom;
      mem_gnt = ($urandom % 4) != 0;
      mem_rvalid = osq.size() > 0 && ($urandom % 3) != 0;
      mem_rdata = $urandom;
      mem_err = ($urandom % 8) == 0;
      inst_ready = ($urandom % 4) != 0;
      #1 model_step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
